// File: rtl/gpio_irq_pkg.sv
// Shared constants for the GPIO pin-conditioning and interrupt stage.
// Register offsets and the 2-bit register-select encoding.
package gpio_irq_pkg;

    localparam logic [3:0] OFS_RISE_EN = 4'h0;
    localparam logic [3:0] OFS_FALL_EN = 4'h4;
    localparam logic [3:0] OFS_PENDING = 4'h8;
    localparam logic [3:0] OFS_LEVEL   = 4'hc;

    typedef enum logic [1:0] {
        SEL_RISE_EN = OFS_RISE_EN[3:2],
        SEL_FALL_EN = OFS_FALL_EN[3:2],
        SEL_PENDING = OFS_PENDING[3:2],
        SEL_LEVEL   = OFS_LEVEL[3:2]
    } reg_sel_e;

endpackage

// File: rtl/gpio_irq_filter.sv
// One pin: two-flop synchroniser, tick-sampled history and
// filtered level that only moves on a unanimous history.
module gpio_irq_filter #(
    parameter int   FILTER_DEPTH = 3,
    parameter logic RST_VAL      = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_i,
    input  logic pad_i,
    output logic level_o
);

    logic                    sync1_q, sync1_d;
    logic                    sync2_q, sync2_d;
    logic [FILTER_DEPTH-1:0] hist_q, hist_d;
    logic [FILTER_DEPTH-1:0] hist_shift;
    logic                    level_q, level_d;

    if (FILTER_DEPTH == 1) begin : g_d1
        assign hist_shift = sync2_q;
    end else begin : g_dn
        assign hist_shift = {hist_q[FILTER_DEPTH-2:0], sync2_q};
    end

    always_comb begin
        sync1_d = pad_i;
        sync2_d = sync1_q;
        hist_d  = tick_i ? hist_shift : hist_q;
        level_d = level_q;
        // Level follows only a history that agrees in every sample
        if (&hist_d) begin
            level_d = 1'b1;
        end else if (~|hist_d) begin
            level_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= RST_VAL;
            sync2_q <= RST_VAL;
            hist_q  <= {FILTER_DEPTH{RST_VAL}};
            level_q <= RST_VAL;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            hist_q  <= hist_d;
            level_q <= level_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/gpio_irq.sv
// GPIO pad conditioning: debounced levels, edge-pending register
// with write-1-to-clear, and a single level interrupt.
module gpio_irq
    import gpio_irq_pkg::*;
#(
    parameter int          AW           = 32,
    parameter int          DW           = 32,
    parameter int          GPIO_WIDTH   = 32,
    parameter int          FILTER_DEPTH = 3,
    parameter int          SAMPLE_DIV   = 1,
    parameter logic [31:0] FILT_RESET   = 32'hffff_ffff
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr_i,
    input  logic [DW-1:0]         wr_data_i,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr_i,
    output logic [DW-1:0]         rd_data_o,
    input  logic [GPIO_WIDTH-1:0] pad_i,
    output logic [GPIO_WIDTH-1:0] gpio_f_o,
    output logic                  irq_o
);

    localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [GPIO_WIDTH-1:0] F_RST =
        FILT_RESET[GPIO_WIDTH-1:0];

    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  tick;
    logic [GPIO_WIDTH-1:0] lvl;
    logic [GPIO_WIDTH-1:0] lvl_dly_q, lvl_dly_d;
    logic [GPIO_WIDTH-1:0] rise_en_q, rise_en_d;
    logic [GPIO_WIDTH-1:0] fall_en_q, fall_en_d;
    logic [GPIO_WIDTH-1:0] pend_q, pend_d;
    logic                  irq_q, irq_d;
    logic [DW-1:0]         rd_data_q, rd_data_d;
    logic [DW-1:0]         rd_mux;
    logic [GPIO_WIDTH-1:0] wdat;
    logic [GPIO_WIDTH-1:0] rise, fall, set, clr;
    reg_sel_e              wr_sel, rd_sel;
    logic                  unused_bits;

    // Upper address bits are decoded by the bus fabric
    assign unused_bits = ^{wr_addr_i, rd_addr_i, wr_data_i};

    assign wr_sel = reg_sel_e'(wr_addr_i[3:2]);
    assign rd_sel = reg_sel_e'(rd_addr_i[3:2]);
    assign wdat   = wr_data_i[GPIO_WIDTH-1:0];

    always_comb begin
        tick  = (cnt_q == CW'(SAMPLE_DIV - 1));
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_pin
        gpio_irq_filter #(
            .FILTER_DEPTH (FILTER_DEPTH),
            .RST_VAL      (F_RST[i])
        ) u_filt (
            .clk     (clk),
            .rst_n   (rst_n),
            .tick_i  (tick),
            .pad_i   (pad_i[i]),
            .level_o (lvl[i])
        );
    end

    always_comb begin
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        clr       = '0;
        rise      = lvl & ~lvl_dly_q;
        fall      = ~lvl & lvl_dly_q;
        set       = (rise & rise_en_q) | (fall & fall_en_q);
        if (wr_en) begin
            unique case (wr_sel)
                SEL_RISE_EN: rise_en_d = wdat;
                SEL_FALL_EN: fall_en_d = wdat;
                SEL_PENDING: clr       = wdat;
                SEL_LEVEL:   ;
            endcase
        end
        // A new edge outranks a simultaneous clear
        pend_d    = (pend_q & ~clr) | set;
        irq_d     = |pend_q;
        lvl_dly_d = lvl;
    end

    always_comb begin
        rd_mux = '0;
        unique case (rd_sel)
            SEL_RISE_EN: rd_mux[GPIO_WIDTH-1:0] = rise_en_q;
            SEL_FALL_EN: rd_mux[GPIO_WIDTH-1:0] = fall_en_q;
            SEL_PENDING: rd_mux[GPIO_WIDTH-1:0] = pend_q;
            SEL_LEVEL:   rd_mux[GPIO_WIDTH-1:0] = lvl;
        endcase
        rd_data_d = rd_en ? rd_mux : rd_data_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            lvl_dly_q <= F_RST;
            rise_en_q <= '0;
            fall_en_q <= '0;
            pend_q    <= '0;
            irq_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            lvl_dly_q <= lvl_dly_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            pend_q    <= pend_d;
            irq_q     <= irq_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign gpio_f_o  = lvl;
    assign irq_o     = irq_q;
    assign rd_data_o = rd_data_q;

endmodule
